// File: rtl/ifu_axi_fetch_master_pkg.sv
// IFU fetch master shared types and constants.
// Fetch FSM states and instruction-width constants.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        OUT
    } ifu_fetch_state_t;

    localparam int INST_WIDTH = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_axi_fetch_master_if.sv
// AXI-lite style instruction-fetch bus.
// Read channels carry the fetch; write channels exist for compatibility.
interface ifu_axi_fetch_master_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);

    logic [ADDR_WIDTH-1:0]   AR_ADDR;
    logic                    AR_VALID;
    logic                    AR_READY;
    logic [DATA_WIDTH-1:0]   R_DATA;
    logic                    R_VALID;
    logic                    R_READY;
    logic [ADDR_WIDTH-1:0]   AW_ADDR;
    logic                    AW_VALID;
    logic [DATA_WIDTH-1:0]   W_DATA;
    logic [DATA_WIDTH/8-1:0] W_STRB;
    logic                    W_VALID;
    logic                    B_READY;

    modport master (
        output AR_ADDR, AR_VALID,
        input  AR_READY,
        input  R_DATA, R_VALID,
        output R_READY,
        output AW_ADDR, AW_VALID,
        output W_DATA, W_STRB, W_VALID,
        output B_READY
    );

    modport slave (
        input  AR_ADDR, AR_VALID,
        output AR_READY,
        output R_DATA, R_VALID,
        input  R_READY,
        input  AW_ADDR, AW_VALID,
        input  W_DATA, W_STRB, W_VALID,
        input  B_READY
    );

endinterface

// File: rtl/ifu_axi_fetch_master_timer.sv
// Saturating wait-cycle counter for the fetch master.
// expired is high on the cycle the count reaches TIMEOUT and while saturated.
module ifu_fetch_timer #(
    parameter int TIMEOUT = 255,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    // count enabled cycles, hold at TIMEOUT instead of wrapping
    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT)) ||
                     (enable && (count == CW'(TIMEOUT - 1)));

endmodule

// File: rtl/ifu_axi_fetch_master.sv
// IFU instruction-fetch read master: one fetch in flight,
// with redirect flush, misaligned-PC fault and bus timeout.
module ifu_axi_fetch_master
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  PC_VALID,
    output logic                  PC_READY,
    input  logic                  FLUSH,
    output logic [INST_WIDTH-1:0] INST,
    output logic [ADDR_WIDTH-1:0] INST_PC,
    output logic                  INST_FAULT,
    output logic                  INST_VALID,
    input  logic                  INST_READY,
    ifu_axi_fetch_master_if.master bus
);

    ifu_fetch_state_t      state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  fault_q;
    logic                  inst_valid_q;
    logic                  ar_valid_q;
    logic                  r_ready_q;

    logic                  pc_accept;
    logic                  r_hs;
    logic                  expired;
    logic [INST_WIDTH-1:0] inst_sel;

    assign PC_READY  = (state_q == IDLE) && !RESET;
    assign pc_accept = PC_VALID && PC_READY;
    assign r_hs      = bus.R_VALID && r_ready_q;
    assign inst_sel  = pc_q[2] ? bus.R_DATA[2*INST_WIDTH-1:INST_WIDTH]
                               : bus.R_DATA[INST_WIDTH-1:0];

    ifu_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .clear   (RESET || pc_accept),
        .enable  ((state_q == REQ) || (state_q == DROP)),
        .expired (expired)
    );

    // fetch FSM with registered bus and IDU outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            fault_q      <= 1'b0;
            inst_valid_q <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_accept) begin
                        pc_q <= PC;
                        if (PC[1:0] != 2'b00) begin
                            state_q      <= OUT;
                            inst_q       <= '0;
                            fault_q      <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end else begin
                            state_q    <= REQ;
                            ar_valid_q <= 1'b1;
                            r_ready_q  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (FLUSH) begin
                        if (r_hs) begin
                            state_q    <= IDLE;
                            ar_valid_q <= 1'b0;
                            r_ready_q  <= 1'b0;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (r_hs) begin
                        state_q      <= OUT;
                        inst_q       <= inst_sel;
                        fault_q      <= 1'b0;
                        inst_valid_q <= 1'b1;
                        ar_valid_q   <= 1'b0;
                        r_ready_q    <= 1'b0;
                    end else if (expired) begin
                        state_q      <= OUT;
                        inst_q       <= '0;
                        fault_q      <= 1'b1;
                        inst_valid_q <= 1'b1;
                        ar_valid_q   <= 1'b0;
                        r_ready_q    <= 1'b0;
                    end
                end
                DROP: begin
                    if (r_hs || expired) begin
                        state_q    <= IDLE;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b0;
                    end
                end
                OUT: begin
                    if (FLUSH || INST_READY) begin
                        state_q      <= IDLE;
                        inst_valid_q <= 1'b0;
                        fault_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign INST       = inst_q;
    assign INST_PC    = pc_q;
    assign INST_FAULT = fault_q;
    assign INST_VALID = inst_valid_q;

    assign bus.AR_ADDR  = {pc_q[ADDR_WIDTH-1:3], 3'b000};
    assign bus.AR_VALID = ar_valid_q;
    assign bus.R_READY  = r_ready_q;
    assign bus.AW_ADDR  = '0;
    assign bus.AW_VALID = 1'b0;
    assign bus.W_DATA   = '0;
    assign bus.W_STRB   = '0;
    assign bus.W_VALID  = 1'b0;
    assign bus.B_READY  = 1'b0;

endmodule

// File: tb/tb_ifu_axi_fetch_master.sv
// Randomized scoreboard bench for ifu_axi_fetch_master.
// Driver pushes expected IDU transfers; a monitor pops them on handshake.
module tb_ifu_axi_fetch_master;
    import ifu_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [AW-1:0] PC = '0;
    logic          PC_VALID = 1'b0;
    logic          PC_READY;
    logic          FLUSH = 1'b0;
    logic [31:0]   INST;
    logic [AW-1:0] INST_PC;
    logic          INST_FAULT;
    logic          INST_VALID;
    logic          INST_READY = 1'b0;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int exp_xfers = 0;
    exp_t q[$];

    int          slave_lat = 0;
    logic [63:0] slave_data = '0;
    logic [63:0] exp_addr = '0;
    logic        no_ar = 1'b0;

    always #5 CLK = ~CLK;

    ifu_axi_fetch_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ifu_axi_fetch_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PC         (PC),
        .PC_VALID   (PC_VALID),
        .PC_READY   (PC_READY),
        .FLUSH      (FLUSH),
        .INST       (INST),
        .INST_PC    (INST_PC),
        .INST_FAULT (INST_FAULT),
        .INST_VALID (INST_VALID),
        .INST_READY (INST_READY),
        .bus        (bus)
    );

    function automatic void check(input string nm, input logic [63:0] act,
                                  input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // slave: answers the lat-th address cycle with data, lat 0 = never
    initial begin
        int  req_cnt;
        bit  hs;
        req_cnt = 0;
        hs = 0;
        bus.AR_READY = 1'b0;
        bus.R_VALID = 1'b0;
        bus.R_DATA = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                req_cnt = 0;
                hs = 0;
                bus.AR_READY = 1'b0;
                bus.R_VALID = 1'b0;
            end else if (bus.AR_VALID) begin
                if (no_ar) check("no_ar", bus.AR_VALID, 0);
                check("ar_addr", bus.AR_ADDR, exp_addr);
                check("r_ready", bus.R_READY, 1);
                req_cnt++;
                if (slave_lat != 0 && req_cnt == slave_lat) begin
                    bus.AR_READY = 1'b1;
                    bus.R_VALID = 1'b1;
                    bus.R_DATA = slave_data;
                    hs = 1;
                end else begin
                    bus.AR_READY = 1'b0;
                    bus.R_VALID = 1'b0;
                    bus.R_DATA = {$urandom, $urandom};
                end
            end else begin
                if (req_cnt > 0 && !hs) check("timeout_cycles", req_cnt, TO);
                req_cnt = 0;
                hs = 0;
                bus.AR_READY = 1'b0;
                bus.R_VALID = 1'b0;
            end
        end
    end

    // monitor: compares each IDU transfer and output stability under stall
    initial begin
        bit          hold;
        logic [31:0] p_inst;
        logic [63:0] p_pc;
        logic        p_fault;
        exp_t        e;
        hold = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("stall_inst", INST, p_inst);
                    check("stall_pc", INST_PC, p_pc);
                    check("stall_fault", INST_FAULT, p_fault);
                end
                if (INST_VALID && INST_READY && !FLUSH) begin
                    xfers++;
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_xfer: got pc %h expected none", INST_PC);
                    end else begin
                        e = q.pop_front();
                        check("inst", INST, e.inst);
                        check("inst_pc", INST_PC, e.pc);
                        check("inst_fault", INST_FAULT, e.fault);
                    end
                end
                hold = INST_VALID && !INST_READY && !FLUSH;
                p_inst = INST;
                p_pc = INST_PC;
                p_fault = INST_FAULT;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (!PC_READY && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("idle_wait", PC_READY, 1);
    endtask

    // fmode: 0 normal, 1 flush in REQ cycle fcyc, 2 flush with R handshake, 3 flush in OUT
    task automatic run_txn(input logic [63:0] pc, input logic [63:0] data,
                           input int lat, input int fmode, input int fcyc,
                           input int bp);
        bit   mis;
        exp_t e;
        int   n;
        int   want_n;
        mis = (pc[1:0] != 2'b00);
        wait_idle();
        slave_lat = lat;
        slave_data = data;
        exp_addr = {pc[63:3], 3'b000};
        no_ar = mis;
        if (fmode == 0) begin
            e.pc = pc;
            e.fault = mis || (lat == 0);
            e.inst = e.fault ? 32'h0 : (pc[2] ? data[63:32] : data[31:0]);
            q.push_back(e);
            exp_xfers++;
        end
        @(posedge CLK); #1;
        PC = pc;
        PC_VALID = 1'b1;
        @(posedge CLK); #1;
        PC_VALID = 1'b0;
        PC = {$urandom, $urandom};
        if (fmode == 1 || fmode == 2) begin
            repeat (fcyc - 1) begin
                @(posedge CLK); #1;
            end
            FLUSH = 1'b1;
            @(posedge CLK); #1;
            FLUSH = 1'b0;
            n = 0;
            @(negedge CLK);
            while (!PC_READY && n < 40) begin
                check("drop_no_out", INST_VALID, 0);
                @(negedge CLK);
                n++;
            end
            check("flush_idle", PC_READY, 1);
            check("flush_no_out", INST_VALID, 0);
        end else begin
            n = 0;
            @(negedge CLK);
            while (!INST_VALID && n < 40) begin
                @(negedge CLK);
                n++;
            end
            check("out_wait", INST_VALID, 1);
            want_n = mis ? 0 : (lat == 0 ? TO : lat);
            check("out_latency", n, want_n);
            repeat (bp) @(posedge CLK);
            @(posedge CLK); #1;
            INST_READY = 1'b1;
            FLUSH = (fmode == 3);
            @(posedge CLK); #1;
            INST_READY = 1'b0;
            FLUSH = 1'b0;
            @(negedge CLK);
            check("post_valid", INST_VALID, 0);
            check("post_idle", PC_READY, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc;
        int lat;
        int fmode;
        int fcyc;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_pc_ready", PC_READY, 0);
        check("rst_ar_valid", bus.AR_VALID, 0);
        check("rst_r_ready", bus.R_READY, 0);
        check("rst_inst_valid", INST_VALID, 0);
        check("rst_inst_fault", INST_FAULT, 0);
        check("rst_inst", INST, 0);
        check("rst_inst_pc", INST_PC, 0);
        RESET = 1'b0;

        run_txn(64'h8000_0000, 64'h0000_0073_0010_0093, 2, 0, 0, 0);
        run_txn(64'h8000_0004, 64'h0000_0073_0010_0093, 3, 0, 0, 1);
        run_txn(64'h8000_0002, 64'h0, 2, 0, 0, 0);
        run_txn(64'h8000_0010, 64'h1111_2222_3333_4444, 4, 1, 1, 0);
        run_txn(64'h8000_0100, 64'hdead_beef_cafe_f00d, 2, 0, 0, 0);
        run_txn(64'h8000_0020, 64'h5555_6666_7777_8888, 2, 0, 0, 5);
        run_txn(64'h8000_0024, 64'h5555_6666_7777_8888, 2, 3, 0, 5);
        run_txn(64'h8000_0040, 64'h0, 0, 0, 0, 0);
        run_txn(64'h8000_0048, 64'h0, 0, 1, 3, 0);
        run_txn(64'h8000_0050, 64'h9999_aaaa_bbbb_cccc, 5, 2, 5, 0);

        for (int i = 0; i < 40; i++) begin
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            else pc[1:0] = 2'b00;
            lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, 7);
            if (pc[1:0] != 2'b00) fmode = ($urandom_range(0, 3) == 0) ? 3 : 0;
            else fmode = $urandom_range(0, 3);
            if (fmode == 2 && lat == 0) fmode = 1;
            if (fmode == 1) fcyc = $urandom_range(1, (lat == 0) ? TO - 1 : lat - 1);
            else if (fmode == 2) fcyc = lat;
            else fcyc = 0;
            run_txn(pc, {$urandom, $urandom}, lat, fmode, fcyc, $urandom_range(0, 5));
        end

        wait_idle();
        slave_lat = 0;
        exp_addr = 64'h8000_0080;
        no_ar = 1'b0;
        @(posedge CLK); #1;
        PC = 64'h8000_0080;
        PC_VALID = 1'b1;
        @(posedge CLK); #1;
        PC_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("mid_rst_ar_valid", bus.AR_VALID, 0);
        check("mid_rst_r_ready", bus.R_READY, 0);
        check("mid_rst_inst_valid", INST_VALID, 0);
        check("mid_rst_fault", INST_FAULT, 0);
        check("mid_rst_inst", INST, 0);
        check("mid_rst_inst_pc", INST_PC, 0);
        check("mid_rst_pc_ready", PC_READY, 0);
        #1;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("post_rst_no_out", INST_VALID, 0);
        check("tie_off",
              {63'(bus.AW_ADDR | bus.W_DATA), bus.AW_VALID | bus.W_VALID | bus.B_READY | (|bus.W_STRB)},
              64'h0);
        check("xfer_count", xfers, exp_xfers);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
